// File: rtl/uart_word_tx.sv
// Word-to-byte transmit front end for uart_tx: buffers 16-bit words in a FIFO and
// sends each as two bytes (low first) using the start_n / ready_to_send handshake.
module uart_word_tx #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              word_in,
    input  logic                     word_valid,
    output logic                     word_ready,
    output logic [7:0]               tx_byte,
    output logic                     tx_start_n,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              words_sent,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT);

    // System side: word_in is taken on a rising edge where word_valid and word_ready
    // are both high. Line side: one low cycle on tx_start_n requests a byte, uart_tx
    // acknowledges by dropping tx_ready and signals completion by raising it again.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   word_reg_q, word_reg_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_start_n_q, tx_start_n_d;
    logic          byte_sel_q, byte_sel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   words_sent_q, words_sent_d;

    logic          full;
    logic          empty;
    logic          push;
    logic [15:0]   head;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // A full FIFO refuses the push even if the head leaves this same cycle.
        push  = word_valid && !full;
        head  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        word_reg_d   = word_reg_q;
        tx_byte_d    = tx_byte_q;
        byte_sel_d   = byte_sel_q;
        timer_d      = timer_q;
        words_sent_d = words_sent_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case (state_q)
            IDLE: begin
                if (!empty && tx_ready) begin
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    word_reg_d = head;
                    tx_byte_d  = head[7:0];
                    byte_sel_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // No acknowledge within the window: pulse again with the same byte.
                if (!tx_ready) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TIMER_END) begin
                    state_d = START;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (!byte_sel_q) begin
                        tx_byte_d  = word_reg_q[15:8];
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else begin
                        words_sent_d = words_sent_q + 16'd1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tx_start_n_d = (state_d != START);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_reg_q   <= '0;
            tx_byte_q    <= '0;
            tx_start_n_q <= 1'b1;
            byte_sel_q   <= 1'b0;
            timer_q      <= '0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            word_reg_q   <= word_reg_d;
            tx_byte_q    <= tx_byte_d;
            tx_start_n_q <= tx_start_n_d;
            byte_sel_q   <= byte_sel_d;
            timer_q      <= timer_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= word_in;
        end
    end

    assign word_ready = !full;
    assign level      = wr_ptr_q - rd_ptr_q;
    assign busy       = (state_q != IDLE) || !empty;
    assign tx_byte    = tx_byte_q;
    assign tx_start_n = tx_start_n_q;
    assign words_sent = words_sent_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Randomized bench for uart_word_tx: a behavioural uart_tx model on the line side and
// a byte-level expected queue built from the words the system side hands over.
module tb_uart_word_tx;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;
    localparam int BIT_CYC = 2;
    localparam int FRAME   = 10 * BIT_CYC;

    logic        clk;
    logic        rst;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  tx_byte;
    logic        tx_start_n;
    wire         tx_ready;
    logic        busy;
    logic [3:0]  level;
    logic [15:0] words_sent;
    logic [1:0]  dbg_state;

    uart_word_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .tx_byte    (tx_byte),
        .tx_start_n (tx_start_n),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .level      (level),
        .words_sent (words_sent),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- uart_tx model + scoreboard ----------------
    logic [7:0] exp_q[$];
    logic       hold = 1'b0;
    logic       ignore_next = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_abandon = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_cnt = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         rx_count = 0;
    int         long_pulse = 0;
    logic       prev_low = 1'b0;
    int         last_low_cyc = -1000;
    logic       ignored_pending = 1'b0;
    int         timeout_gap = -1;

    assign tx_ready = ~hold & ~m_busy;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (m_busy) begin
                if (!rst) m_abandon = 1'b1;
                m_cnt--;
                if (m_cnt == 0) begin
                    if (!m_abandon) check("byte_stable", tx_byte, m_byte);
                    m_busy = 1'b0;
                end
            end
            if (tx_start_n === 1'b0) begin
                pulses++;
                if (prev_low) long_pulse++;
                if (ignored_pending) begin
                    timeout_gap = cyc - last_low_cyc - 1;
                    ignored_pending = 1'b0;
                end
                last_low_cyc = cyc;
                if (ignore_next) begin
                    ignore_next = 1'b0;
                    ignored_pending = 1'b1;
                end else if (!m_busy && !hold) begin
                    m_busy = 1'b1;
                    m_cnt = FRAME;
                    m_byte = tx_byte;
                    m_abandon = 1'b0;
                    rx_count++;
                    check("exp_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("rx_byte", tx_byte, exp_q.pop_front());
                end
            end
            prev_low = (tx_start_n === 1'b0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [15:0] w);
        int n = 0;
        while (!word_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("push_timeout", n < 5000, 1);
        word_valid = 1'b1;
        word_in = w;
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_sent(input logic [15:0] target, input int limit);
        int n = 0;
        while (words_sent !== target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("sent_timeout", n < limit, 1);
        check("busy_after_last", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] ws_exp;
    logic [15:0] w;
    int          p0;
    int          r0;

    initial begin
        rst = 1'b0;
        word_valid = 1'b0;
        word_in = 16'h0000;
        ws_exp = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_start_n", tx_start_n, 1);
        check("rst_byte", tx_byte, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_ready", word_ready, 1);
        check("rst_sent", words_sent, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single word with latency check.
        p0 = pulses;
        r0 = rx_count;
        word_valid = 1'b1;
        word_in = 16'hA55A;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA5);
        @(negedge clk);
        word_valid = 1'b0;
        check("lat_n0_start", tx_start_n, 1);
        check("lat_n0_level", level, 1);
        @(negedge clk);
        check("lat_n1_start", tx_start_n, 0);
        check("lat_n1_byte", tx_byte, 8'h5A);
        check("lat_n1_level", level, 0);
        @(negedge clk);
        check("lat_n2_start", tx_start_n, 1);
        ws_exp = ws_exp + 16'd1;
        wait_sent(ws_exp, 2000);
        check("single_sent", words_sent, ws_exp);
        check("single_pulses", pulses - p0, 2);
        check("single_rx", rx_count - r0, 2);
        check("single_level", level, 0);

        // Fill past full with line stalled.
        hold = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            check("fill_ready", word_ready, i < DEPTH);
            w = 16'($urandom);
            word_valid = 1'b1;
            word_in = w;
            if (i < DEPTH) begin
                exp_q.push_back(w[7:0]);
                exp_q.push_back(w[15:8]);
            end
            @(negedge clk);
        end
        word_valid = 1'b0;
        check("fill_level", level, DEPTH);
        check("fill_not_ready", word_ready, 0);
        r0 = rx_count;
        hold = 1'b0;
        ws_exp = ws_exp + 16'(DEPTH);
        wait_sent(ws_exp, 5000);
        check("fill_sent", words_sent, ws_exp);
        check("fill_rx", rx_count - r0, 2 * DEPTH);
        check("fill_drained", exp_q.size(), 0);

        // Push coinciding with pop, then random stream.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push_word(16'($urandom));
        check("pp_level_pre", level, 3);
        hold = 1'b0;
        w = 16'($urandom);
        word_valid = 1'b1;
        word_in = w;
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        @(negedge clk);
        word_valid = 1'b0;
        check("pp_level", level, 3);
        check("pp_popped", tx_start_n, 0);
        for (int i = 0; i < 96; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_word(16'($urandom));
        end
        ws_exp = ws_exp + 16'd100;
        wait_sent(ws_exp, 8000);
        check("rand_sent", words_sent, ws_exp);
        check("rand_drained", exp_q.size(), 0);

        // Ignored start pulse must be re-issued after the timeout window.
        ignore_next = 1'b1;
        p0 = pulses;
        r0 = rx_count;
        push_word(16'($urandom));
        ws_exp = ws_exp + 16'd1;
        wait_sent(ws_exp, 2000);
        check("to_gap", timeout_gap, TIMEOUT + 1);
        check("to_pulses", pulses - p0, 3);
        check("to_rx", rx_count - r0, 2);
        check("to_sent", words_sent, ws_exp);

        // Reset during the high byte of the second of three words.
        hold = 1'b1;
        r0 = rx_count;
        for (int i = 0; i < 3; i++) push_word(16'($urandom));
        hold = 1'b0;
        begin
            int n = 0;
            while (rx_count < r0 + 4 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("rst_mid_reach", n < 2000, 1);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_start_n", tx_start_n, 1);
        check("async_byte", tx_byte, 8'h00);
        check("async_busy", busy, 0);
        check("async_level", level, 0);
        check("async_ready", word_ready, 1);
        check("async_sent", words_sent, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        p0 = pulses;
        repeat (200) @(negedge clk);
        check("post_rst_rx", rx_count - r0, 4);
        check("post_rst_pulses", pulses - p0, 0);
        check("post_rst_sent", words_sent, 0);
        check("post_rst_busy", busy, 0);
        ws_exp = 16'h0000;

        // Counter wrap.
        force dut.words_sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.words_sent_q;
        @(negedge clk);
        check("wrap_pre", words_sent, 16'hFFFF);
        push_word(16'($urandom));
        wait_sent(16'h0000, 2000);
        check("wrap_sent", words_sent, 16'h0000);

        check("final_exp_empty", exp_q.size(), 0);
        check("single_low_cycles", long_pulse, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
